// File: rtl/div_pkg.sv
// Purpose: shared FSM encoding and two's-complement helpers for the long divider.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_t (IDLE/DIVIDE/FIX/ERR), div_iter(), twos_neg(), mag_of().
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FIX    = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Helpers work on a 64-bit carrier; callers zero-extend a SIZE-bit word,
    // operate, then truncate back. Negation mod 2^64 truncated to SIZE bits
    // equals negation mod 2^SIZE, so any SIZE <= 64 is handled.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] wide_t;

    function automatic int div_iter(input int size, input int bpc);
        return size / bpc;
    endfunction

    function automatic wide_t twos_neg(input wide_t v);
        return ~v + wide_t'(1);
    endfunction

    // Magnitude of a word whose sign has already been decided by the caller.
    function automatic wide_t mag_of(input wide_t v, input logic neg);
        return neg ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// Purpose: BITS_PER_CYCLE chained restoring-division steps (combinational).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; result valid whenever inputs are.
// Ports: rem_in/rem_out partial remainder (always < divisor), dvd_bits next
//        dividend bits MSB first, dvs divisor magnitude, q_bits quotient bits MSB first.
module div_step #(
    parameter int SIZE           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [SIZE-1:0]           rem_in,
    input  logic [BITS_PER_CYCLE-1:0] dvd_bits,
    input  logic [SIZE-1:0]           dvs,
    output logic [SIZE-1:0]           rem_out,
    output logic [BITS_PER_CYCLE-1:0] q_bits
);

    logic [SIZE-1:0] r;
    logic [SIZE:0]   t;

    always_comb begin
        r      = rem_in;
        t      = '0;
        q_bits = '0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            // Trial value needs SIZE+1 bits: r < dvs, so 2r+1 can overflow SIZE.
            t = {r, dvd_bits[i]};
            if (t >= {1'b0, dvs}) begin
                // Difference is < dvs, so the low SIZE bits hold it exactly.
                r         = t[SIZE-1:0] - dvs;
                q_bits[i] = 1'b1;
            end else begin
                r = t[SIZE-1:0];
            end
        end
        rem_out = r;
    end

endmodule

// File: rtl/long_divider_pipe.sv
// Purpose: multi-cycle signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per cycle.
// Latency: done ITER+1 edges after the start edge; divide-by-zero reports 1 edge after.
// Backpressure: one op in flight; start ignored while busy, accepted again in the done cycle.
// Ports: clk, reset (sync, active-high); start/signed_op/dividend/divisor request;
//        busy, done (1-cycle pulse), error (divisor was zero), quotient/remainder held results.
module long_divider_pipe
    import div_pkg::*;
#(
    parameter int SIZE           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_op,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int ITER = div_iter(SIZE, BITS_PER_CYCLE);
    localparam int CW   = $clog2(ITER) + 1;

    typedef logic [SIZE-1:0] word_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    word_t         acc_q;      // dividend magnitude shifting out, quotient shifting in
    word_t         rem_q;      // partial remainder, always < divisor magnitude
    word_t         dvs_q;
    logic          neg_dvd_q;
    logic          neg_dvs_q;

    logic          dvd_neg, dvs_neg;
    word_t         dvd_mag, dvs_mag;
    word_t         step_rem;
    logic [BITS_PER_CYCLE-1:0] step_q;
    logic          last_iter;

    always_comb begin
        dvd_neg = signed_op & dividend[SIZE-1];
        dvs_neg = signed_op & divisor[SIZE-1];
        dvd_mag = word_t'(mag_of(wide_t'(dividend), dvd_neg));
        dvs_mag = word_t'(mag_of(wide_t'(divisor), dvs_neg));
    end

    assign last_iter = (cnt_q == CW'(ITER - 1));

    div_step #(
        .SIZE           (SIZE),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_in   (rem_q),
        .dvd_bits (acc_q[SIZE-1 -: BITS_PER_CYCLE]),
        .dvs      (dvs_q),
        .rem_out  (step_rem),
        .q_bits   (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ST_ERR : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (last_iter) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // busy drops in the cycle done is high, so a host can chain the next start there.
    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        dvs_q     <= dvs_mag;
                        neg_dvd_q <= dvd_neg;
                        neg_dvs_q <= dvs_neg;
                        // ERR reports the dividend as presented, not its magnitude.
                        acc_q     <= (divisor == '0) ? dividend : dvd_mag;
                    end
                end
                ST_DIVIDE: begin
                    cnt_q <= cnt_q + 1'b1;
                    rem_q <= step_rem;
                    acc_q <= {acc_q[SIZE-BITS_PER_CYCLE-1:0], step_q};
                end
                ST_FIX: begin
                    // Truncation toward zero: quotient sign = XOR of signs,
                    // remainder follows the dividend. MIN/-1 wraps back to MIN.
                    quotient  <= (neg_dvd_q ^ neg_dvs_q) ? word_t'(twos_neg(wide_t'(acc_q))) : acc_q;
                    remainder <= neg_dvd_q ? word_t'(twos_neg(wide_t'(rem_q))) : rem_q;
                    error     <= 1'b0;
                    done      <= 1'b1;
                end
                ST_ERR: begin
                    quotient  <= '1;
                    remainder <= acc_q;
                    error     <= 1'b1;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_long_divider_pipe.sv
// Purpose: self-checking bench for long_divider_pipe against an arithmetic reference.
// Latency: checks done timing, busy span and single done pulse per operation.
// Backpressure: exercises start-while-busy, start-in-done-cycle and mid-op reset.
module tb_long_divider_pipe;

    localparam int SIZE   = 32;
    localparam int BPC    = 1;
    localparam int ITER   = SIZE / BPC;
    localparam int N_RAND = 1500;

    typedef logic [SIZE-1:0] word_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    logic  signed_op;
    word_t dividend;
    word_t divisor;
    logic  busy;
    logic  done;
    logic  error;
    word_t quotient;
    word_t remainder;

    int checks   = 0;
    int failures = 0;

    word_t min_w;
    word_t ones_w;

    always #5 clk = ~clk;

    long_divider_pipe #(
        .SIZE           (SIZE),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .quotient  (quotient),
        .remainder (remainder)
    );

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endfunction

    // Reference: plain integer division; SV '/' and '%' truncate toward zero.
    function automatic void model(input logic sop, input word_t a, input word_t b,
                                  output word_t q, output word_t r, output logic e);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 0) begin
            q = '1;
            r = a;
            e = 1'b1;
        end else if (sop) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = word_t'(sa / sb);
            r  = word_t'(sa % sb);
            e  = 1'b0;
        end else begin
            ua = longint'(a);
            ub = longint'(b);
            q  = word_t'(ua / ub);
            r  = word_t'(ua % ub);
            e  = 1'b0;
        end
    endfunction

    // Called #1 after an edge; start is sampled at the next edge, then operands are scrambled.
    task automatic launch(input logic sop, input word_t a, input word_t b);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        signed_op = 1'($urandom);
        dividend  = word_t'($urandom);
        divisor   = word_t'($urandom);
    endtask

    // Called #1 after the start edge; returns in the done cycle.
    task automatic wait_done(input string tag, input int exp_lat, input logic noise);
        int lat  = 0;
        int bcnt = 0;
        while (done !== 1'b1 && lat <= ITER + 4) begin
            if (busy === 1'b1) bcnt++;
            if (noise && lat >= 4 && lat < 10) begin
                start     = 1'b1;
                signed_op = 1'($urandom);
                dividend  = word_t'($urandom);
                divisor   = word_t'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " done"},     64'(done), 64'(1));
        chk({tag, " latency"},  64'(lat),  64'(exp_lat));
        chk({tag, " busy_len"}, 64'(bcnt), 64'(exp_lat));
        chk({tag, " busy_low_in_done"}, 64'(busy), 64'(0));
    endtask

    task automatic check_res(input string tag, input logic sop, input word_t a, input word_t b);
        word_t q, r;
        logic  e;
        model(sop, a, b, q, r, e);
        chk({tag, " quotient"},  64'(quotient),  64'(q));
        chk({tag, " remainder"}, 64'(remainder), 64'(r));
        chk({tag, " error"},     64'(error),     64'(e));
    endtask

    task automatic full_op(input string tag, input logic sop, input word_t a, input word_t b);
        launch(sop, a, b);
        wait_done(tag, (b == 0) ? 1 : ITER + 1, 1'b0);
        check_res(tag, sop, a, b);
    endtask

    initial begin
        int    dcnt;
        word_t a, b, a2, b2;
        logic  sop;
        int    kind;

        min_w  = '0;
        min_w[SIZE-1] = 1'b1;
        ones_w = '1;

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset error", 64'(error), 64'(0));
        chk("reset quotient", 64'(quotient), 64'(0));
        chk("reset remainder", 64'(remainder), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-derived results.
        launch(1'b0, word_t'(100), word_t'(7));
        wait_done("u100/7", ITER + 1, 1'b0);
        chk("u100/7 q", 64'(quotient), 64'(14));
        chk("u100/7 r", 64'(remainder), 64'(2));
        chk("u100/7 e", 64'(error), 64'(0));
        @(posedge clk); #1;
        chk("done single pulse", 64'(done), 64'(0));

        launch(1'b1, word_t'(-100), word_t'(7));
        wait_done("s-100/7", ITER + 1, 1'b0);
        chk("s-100/7 q", 64'(quotient), 64'(word_t'(-14)));
        chk("s-100/7 r", 64'(remainder), 64'(word_t'(-2)));

        launch(1'b1, word_t'(100), word_t'(-7));
        wait_done("s100/-7", ITER + 1, 1'b0);
        chk("s100/-7 q", 64'(quotient), 64'(word_t'(-14)));
        chk("s100/-7 r", 64'(remainder), 64'(2));

        launch(1'b1, word_t'(-100), word_t'(-7));
        wait_done("s-100/-7", ITER + 1, 1'b0);
        chk("s-100/-7 q", 64'(quotient), 64'(14));
        chk("s-100/-7 r", 64'(remainder), 64'(word_t'(-2)));

        launch(1'b0, word_t'(32'h1234), word_t'(0));
        wait_done("div0", 1, 1'b0);
        chk("div0 q", 64'(quotient), 64'(ones_w));
        chk("div0 r", 64'(remainder), 64'(word_t'(32'h1234)));
        chk("div0 e", 64'(error), 64'(1));

        launch(1'b1, min_w, ones_w);
        wait_done("sMIN/-1", ITER + 1, 1'b0);
        chk("sMIN/-1 q", 64'(quotient), 64'(min_w));
        chk("sMIN/-1 r", 64'(remainder), 64'(0));
        chk("sMIN/-1 e", 64'(error), 64'(0));

        launch(1'b0, min_w, ones_w);
        wait_done("uMIN/-1", ITER + 1, 1'b0);
        chk("uMIN/-1 q", 64'(quotient), 64'(0));
        chk("uMIN/-1 r", 64'(remainder), 64'(min_w));

        // Start pulses while busy must be ignored.
        launch(1'b0, word_t'(1000), word_t'(9));
        wait_done("noise", ITER + 1, ITER >= 12);
        check_res("noise", 1'b0, word_t'(1000), word_t'(9));
        repeat (3) @(posedge clk);
        #1;
        chk("noise held q", 64'(quotient), 64'(111));
        chk("noise held busy", 64'(busy), 64'(0));

        // Start in the done cycle is accepted; done pulses once per op.
        launch(1'b1, word_t'(77), word_t'(-5));
        wait_done("b2b first", ITER + 1, 1'b0);
        check_res("b2b first", 1'b1, word_t'(77), word_t'(-5));
        launch(1'b0, word_t'(50), word_t'(6));
        chk("b2b done dropped", 64'(done), 64'(0));
        chk("b2b second busy", 64'(busy), 64'(1));
        chk("b2b first held q", 64'(quotient), 64'(word_t'(-15)));
        wait_done("b2b second", ITER + 1, 1'b0);
        check_res("b2b second", 1'b0, word_t'(50), word_t'(6));

        // Reset at edge 10 of an op aborts it without a done pulse.
        launch(1'b0, word_t'(100), word_t'(3));
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", 64'(busy), 64'(0));
        chk("midreset done", 64'(done), 64'(0));
        chk("midreset q", 64'(quotient), 64'(0));
        chk("midreset r", 64'(remainder), 64'(0));
        chk("midreset e", 64'(error), 64'(0));
        dcnt = 0;
        repeat (ITER + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcnt++;
        end
        chk("midreset no done", 64'(dcnt), 64'(0));
        full_op("after reset", 1'b0, word_t'(200), word_t'(13));

        // Randomized operations against the reference.
        for (int n = 0; n < N_RAND; n++) begin
            sop  = 1'($urandom);
            kind = $urandom_range(0, 9);
            a    = word_t'($urandom);
            b    = word_t'($urandom);
            case (kind)
                0: b = '0;
                1: b = ($urandom_range(0, 1) == 0) ? word_t'(1) : ones_w;
                2: begin a = min_w; b = ones_w; end
                3: b = word_t'($urandom_range(1, 15));
                4: a = word_t'($urandom_range(0, 20));
                default: ;
            endcase
            launch(sop, a, b);
            wait_done($sformatf("rand%0d", n), (b == 0) ? 1 : ITER + 1, 1'b0);
            check_res($sformatf("rand%0d", n), sop, a, b);
            // Occasionally chain directly from the done cycle.
            if ($urandom_range(0, 3) == 0) begin
                a2 = word_t'($urandom);
                b2 = word_t'($urandom_range(0, 255));
                launch(1'b1, a2, b2);
                wait_done($sformatf("chain%0d", n), (b2 == 0) ? 1 : ITER + 1, 1'b0);
                check_res($sformatf("chain%0d", n), 1'b1, a2, b2);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
